// File: rtl/ltc2308_pkg.sv
// rtl/ltc2308_pkg.sv - shared types and constants for the LTC2308 reader
package ltc2308_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONVST,
    CONV,
    SHIFT,
    DONE
  } state_t;

  localparam int DATA_W      = 12;
  localparam int CFG_W       = 6;
  localparam int SCK_PERIODS = 12;
  localparam int SCK_CNT_W   = $clog2(SCK_PERIODS + 1);

  // Bit positions inside the 6-bit LTC2308 configuration word
  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  function automatic logic [CFG_W-1:0] cfg_word(input logic [2:0] ch, input logic uni);
    logic [CFG_W-1:0] w;
    w          = '0;
    w[CFG_SD]  = 1'b1;
    w[CFG_OS]  = ch[0];
    w[CFG_S1]  = ch[2];
    w[CFG_S0]  = ch[1];
    w[CFG_UNI] = uni;
    w[CFG_SLP] = 1'b0;
    return w;
  endfunction

endpackage

// File: rtl/ltc2308_reader_if.sv
// rtl/ltc2308_reader_if.sv - LTC2308 serial pin bundle
interface ltc2308_reader_if;

  logic adc_convst;
  logic adc_sck;
  logic adc_sdi;
  logic adc_sdo;

  modport master (output adc_convst, output adc_sck, output adc_sdi, input adc_sdo);
  modport slave  (input adc_convst, input adc_sck, input adc_sdi, output adc_sdo);

endinterface

// File: rtl/ltc2308_sck_gen.sv
// rtl/ltc2308_sck_gen.sv - SCK level, edge strobes and period count for one shift burst
module ltc2308_sck_gen
  import ltc2308_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  output logic                 sck,
  output logic                 rise,
  output logic                 fall,
  output logic [SCK_CNT_W-1:0] period
);

  logic [7:0] div_cnt;
  logic       div_end;

  assign div_end = (div_cnt == 8'(CLK_DIV - 1));
  // Strobes mark the clk edge on which the registered sck level changes
  assign rise    = run && !sck && div_end;
  assign fall    = run && sck && div_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sck     <= 1'b0;
      period  <= '0;
    end else if (!run) begin
      div_cnt <= '0;
      sck     <= 1'b0;
      period  <= '0;
    end else if (div_end) begin
      div_cnt <= '0;
      sck     <= ~sck;
      if (sck) begin
        period <= period + 1'b1;
      end
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/ltc2308_reader.sv
// rtl/ltc2308_reader.sv - LTC2308 free-running channel scanner, one tagged result per frame
module ltc2308_reader
  import ltc2308_pkg::*;
#(
  parameter int CLK_DIV       = 2,
  parameter int CONVST_CYCLES = 2,
  parameter int CONV_CYCLES   = 80,
  parameter int NUM_CH        = 8,
  parameter int UNIPOLAR      = 1
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             enable,
  ltc2308_reader_if.master adc,
  output logic [15:0]      adcvalue,
  output logic             adcvalid
);

  state_t               state, state_n;
  logic [9:0]           cnt;
  logic                 first;
  logic [2:0]           tx_ch, prev_ch;
  logic [CFG_W-1:0]     cfg, tx_sr;
  logic [DATA_W-1:0]    rx_sr;
  logic                 sck, sck_rise, sck_fall;
  logic [SCK_CNT_W-1:0] sck_period;

  assign cfg         = cfg_word(tx_ch, UNIPOLAR != 0);
  assign adc.adc_sck = sck;

  ltc2308_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk    (clk_clk),
    .rst_n  (reset_reset_n),
    .run    (state == SHIFT),
    .sck    (sck),
    .rise   (sck_rise),
    .fall   (sck_fall),
    .period (sck_period)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (enable) state_n = CONVST;
      CONVST:  if (cnt == 10'(CONVST_CYCLES - 1)) state_n = CONV;
      CONV:    if (cnt == 10'(CONV_CYCLES - 1)) state_n = SHIFT;
      SHIFT:   if (sck_fall && sck_period == SCK_CNT_W'(SCK_PERIODS - 1)) state_n = DONE;
      DONE:    state_n = enable ? CONVST : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      first          <= 1'b1;
      tx_ch          <= '0;
      prev_ch        <= '0;
      tx_sr          <= '0;
      rx_sr          <= '0;
      adc.adc_convst <= 1'b0;
      adc.adc_sdi    <= 1'b0;
      adcvalue       <= '0;
      adcvalid       <= 1'b0;
    end else begin
      state          <= state_n;
      adc.adc_convst <= (state_n == CONVST);
      adcvalid       <= 1'b0;

      if (state_n == state && (state == CONVST || state == CONV)) begin
        cnt <= cnt + 10'd1;
      end else begin
        cnt <= '0;
      end

      // Config bits change only on SCK falls, so each is stable across the ADC's rising edge
      if (state == CONV && state_n == SHIFT) begin
        adc.adc_sdi <= cfg[CFG_W-1];
        tx_sr       <= {cfg[CFG_W-2:0], 1'b0};
      end else if (sck_fall) begin
        adc.adc_sdi <= tx_sr[CFG_W-1];
        tx_sr       <= {tx_sr[CFG_W-2:0], 1'b0};
      end

      if (sck_rise) begin
        rx_sr <= {rx_sr[DATA_W-2:0], adc.adc_sdo};
      end

      if (state == IDLE && state_n == CONVST) begin
        tx_ch <= '0;
        first <= 1'b1;
      end

      // Data shifted out now was converted with the config sent in the previous frame
      if (state == DONE) begin
        if (!first) begin
          adcvalue <= {1'b0, prev_ch, rx_sr};
          adcvalid <= 1'b1;
        end
        first   <= 1'b0;
        prev_ch <= tx_ch;
        tx_ch   <= (tx_ch == 3'(NUM_CH - 1)) ? 3'd0 : tx_ch + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_ltc2308_reader.sv
// tb/tb_ltc2308_reader.sv - randomized bench with frame-timeline reference model
module tb_ltc2308_reader;

  localparam int D   = 2;
  localparam int CS  = 2;
  localparam int CV  = 80;
  localparam int NCH = 8;
  localparam int SB  = CS + CV;
  localparam int F   = CS + CV + 24 * D + 1;

  logic        clk;
  logic        reset_reset_n;
  logic        enable;
  logic [15:0] adcvalue;
  logic        adcvalid;

  logic        rst2;
  logic        enable2;
  logic [15:0] value2;
  logic        valid2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n3a5c    = 0;

  ltc2308_reader_if adc_if ();
  ltc2308_reader_if if2 ();

  ltc2308_reader dut (
    .clk_clk       (clk),
    .reset_reset_n (reset_reset_n),
    .enable        (enable),
    .adc           (adc_if),
    .adcvalue      (adcvalue),
    .adcvalid      (adcvalid)
  );

  ltc2308_reader #(.CLK_DIV(1), .NUM_CH(1)) dut_n1 (
    .clk_clk       (clk),
    .reset_reset_n (rst2),
    .enable        (enable2),
    .adc           (if2),
    .adcvalue      (value2),
    .adcvalid      (valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ADC model: converts with the config captured during the previous shift burst
  logic [11:0] adc_result, adc_sh;
  logic [5:0]  adc_cfg_sr, adc_pend_cfg;
  int          adc_nb;
  logic [5:0]  cfg_q[$];

  initial begin
    adc_if.adc_sdo = 1'b0;
    adc_result     = '0;
    adc_sh         = '0;
    adc_cfg_sr     = '0;
    adc_pend_cfg   = '0;
    adc_nb         = 0;
  end

  always @(posedge adc_if.adc_convst) begin
    logic [2:0] c;
    c              = {adc_pend_cfg[3], adc_pend_cfg[2], adc_pend_cfg[4]};
    adc_result     = (c == 3'd3) ? 12'hA5C : 12'($urandom_range(0, 4095));
    adc_sh         = adc_result;
    adc_nb         = 0;
    adc_if.adc_sdo = adc_sh[11];
  end

  always @(posedge adc_if.adc_sck) begin
    if (adc_nb < 6) begin
      adc_cfg_sr = {adc_cfg_sr[4:0], adc_if.adc_sdi};
      if (adc_nb == 5) begin
        adc_pend_cfg = adc_cfg_sr;
        cfg_q.push_back(adc_cfg_sr);
      end
    end
    adc_nb++;
    adc_sh         = {adc_sh[10:0], 1'b0};
    adc_if.adc_sdo = adc_sh[11];
  end

  // Reference model: position within a fixed-length frame timeline
  bit          m_active = 0;
  bit          m_first  = 1;
  int          m_pos    = 0;
  int          m_ch     = 0;
  int          m_prev   = 0;
  logic        m_valid  = 1'b0;
  logic [15:0] m_value  = '0;

  always @(posedge clk) begin
    if (!reset_reset_n) begin
      m_active = 0; m_first = 1; m_pos = 0; m_ch = 0; m_prev = 0;
      m_valid = 1'b0; m_value = '0;
    end else begin
      m_valid = 1'b0;
      if (!m_active) begin
        if (enable) begin
          m_active = 1; m_pos = 0; m_first = 1; m_ch = 0;
        end
      end else if (m_pos == F - 1) begin
        if (!m_first) begin
          m_valid = 1'b1;
          m_value = {1'b0, 3'(m_prev), adc_result};
        end
        m_first = 0;
        m_prev  = m_ch;
        m_ch    = (m_ch + 1) % NCH;
        if (enable) m_pos = 0;
        else m_active = 0;
      end else begin
        m_pos++;
      end
    end
  end

  function automatic logic e_convst();
    return m_active && m_pos < CS;
  endfunction

  function automatic logic e_sck();
    int c;
    c = m_pos - SB;
    return m_active && c >= 0 && c < 24 * D && ((c / D) % 2 == 1);
  endfunction

  function automatic logic e_sdi();
    int c, k;
    logic [2:0] ch;
    logic [5:0] w;
    c  = m_pos - SB;
    k  = c / (2 * D);
    ch = 3'(m_ch);
    w  = {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
    if (!m_active || c < 0 || c >= 24 * D || k >= 6) return 1'b0;
    return w[5-k];
  endfunction

  always @(negedge clk) begin
    chk("convst", 32'(adc_if.adc_convst), 32'(e_convst()));
    chk("sck", 32'(adc_if.adc_sck), 32'(e_sck()));
    chk("sdi", 32'(adc_if.adc_sdi), 32'(e_sdi()));
    chk("adcvalid", 32'(adcvalid), 32'(m_valid));
    chk("adcvalue", 32'(adcvalue), 32'(m_value));
    if (adcvalid && adcvalue == 16'h3A5C) n3a5c++;
  end

  // Second instance: CLK_DIV=1, NUM_CH=1, fed random SDO bits
  int   sck_hi2 = 0;
  int   dbl2    = 0;
  int   t_last2 = -1;
  logic prev2   = 1'b0;

  initial if2.adc_sdo = 1'b0;

  always @(negedge clk) begin
    if (rst2) begin
      if (if2.adc_sck) begin
        sck_hi2++;
        if (prev2) dbl2++;
      end
      prev2 = if2.adc_sck;
      if (valid2) begin
        chk("n1_ch_field", 32'(value2[14:12]), 32'd0);
        if (t_last2 >= 0) begin
          chk("n1_frame_len", cyc - t_last2, 107);
          chk("n1_sck_highs", sck_hi2, 12);
          chk("n1_sck_double_high", dbl2, 0);
        end
        t_last2 = cyc;
        sck_hi2 = 0;
        dbl2    = 0;
      end
      if2.adc_sdo = 1'($urandom_range(0, 1));
    end
  end

  task automatic wait_valid(input int bound, output int t);
    t = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (adcvalid) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      checks++; failures++;
      $display("FAIL wait_valid actual=timeout required=pulse within %0d cycles", bound);
    end
  endtask

  task automatic wait_sck_high(input int bound);
    bit seen;
    seen = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (adc_if.adc_sck) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL wait_sck actual=timeout required=sck high within %0d cycles", bound);
    end
  endtask

  logic [5:0] exp_cfg_seq [9] = '{6'h22, 6'h32, 6'h26, 6'h36, 6'h2A, 6'h3A, 6'h2E, 6'h3E, 6'h22};

  initial begin
    int t_en, t_cs, t1, t2, nv, hold;
    reset_reset_n = 1'b0;
    enable        = 1'b0;
    rst2          = 1'b0;
    enable2       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_convst", 32'(adc_if.adc_convst), 32'd0);
    chk("rst_sck", 32'(adc_if.adc_sck), 32'd0);
    chk("rst_sdi", 32'(adc_if.adc_sdi), 32'd0);
    chk("rst_adcvalue", 32'(adcvalue), 32'h0);
    chk("rst_adcvalid", 32'(adcvalid), 32'd0);
    reset_reset_n = 1'b1;
    rst2          = 1'b1;
    enable2       = 1'b1;
    repeat (4) @(negedge clk);

    // Startup latency, CONVST width, pipeline latency and frame period
    cfg_q.delete();
    n3a5c  = 0;
    enable = 1'b1;
    t_en   = cyc;
    chk("convst_before_start", 32'(adc_if.adc_convst), 32'd0);
    @(negedge clk);
    t_cs = cyc;
    chk("convst_cycle1", 32'(adc_if.adc_convst), 32'd1);
    @(negedge clk);
    chk("convst_cycle2", 32'(adc_if.adc_convst), 32'd1);
    @(negedge clk);
    chk("convst_cycle3", 32'(adc_if.adc_convst), 32'd0);
    wait_valid(400, t1);
    chk("first_valid_latency", t1 - t_cs, 262);
    chk("first_value", 32'(adcvalue[15:12]), 32'h0);
    wait_valid(200, t2);
    chk("frame_period", t2 - t1, 131);
    for (int i = 0; i < 7; i++) wait_valid(200, t2);
    chk("ch3_value_pulses", n3a5c, 1);
    chk("cfg_words_seen", 32'(cfg_q.size() >= 9), 32'd1);
    if (cfg_q.size() >= 9) begin
      for (int i = 0; i < 9; i++) chk($sformatf("cfg_word_%0d", i), 32'(cfg_q[i]), 32'(exp_cfg_seq[i]));
    end

    // Enable dropped mid-shift: frame completes and publishes once
    wait_sck_high(200);
    enable = 1'b0;
    nv = 0;
    repeat (300) begin
      @(negedge clk);
      if (adcvalid) nv++;
    end
    chk("drop_valid_count", nv, 1);
    chk("drop_convst", 32'(adc_if.adc_convst), 32'd0);
    chk("drop_sck", 32'(adc_if.adc_sck), 32'd0);
    chk("drop_sdi", 32'(adc_if.adc_sdi), 32'd0);

    // Reset in the middle of a shift burst
    enable = 1'b1;
    wait_valid(400, t1);
    wait_sck_high(200);
    #2 reset_reset_n = 1'b0;
    #1;
    chk("midrst_convst", 32'(adc_if.adc_convst), 32'd0);
    chk("midrst_sck", 32'(adc_if.adc_sck), 32'd0);
    chk("midrst_sdi", 32'(adc_if.adc_sdi), 32'd0);
    chk("midrst_adcvalue", 32'(adcvalue), 32'h0);
    chk("midrst_adcvalid", 32'(adcvalid), 32'd0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    reset_reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_adcvalue", 32'(adcvalue), 32'h0);
    enable = 1'b1;
    t_en   = cyc;
    wait_valid(400, t1);
    chk("reenable_latency", t1 - t_en, 263);

    // Random enable toggling with occasional asynchronous resets
    for (int it = 0; it < 25; it++) begin
      enable = 1'($urandom_range(0, 1));
      hold   = $urandom_range(1, 350);
      repeat (hold) @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        #2 reset_reset_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        reset_reset_n = 1'b1;
      end
    end
    enable = 1'b0;
    repeat (200) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=still running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
